serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller: accepts WIDTH-bit operand pairs over a valid/ready handshake and sequences a single one-bit full-adder cell through WIDTH cycles, LSB first, with a registered carry. It presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the area-minimal alternative to a ripple adder, used wherever one full-adder cell is time-shared across all bit positions.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A, sampled on accept.
- b  in  WIDTH  operand B, sampled on accept.
- cin  in  1  carry-in, sampled on accept.
- sub  in  1  subtract select, sampled on accept; port exists only with SERIAL_ADD_SUB_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, registered.
- cout  out  1  final carry, registered.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load a_sh<=a, b_sh<=b, carry<=cin, acc<=0, bit count<=0; go to RUN.
- RUN, one bit per cycle:
  - Feed a_sh[0], b_sh[0] and carry to the full-adder cell.
  - Shift the cell's sum into acc[WIDTH-1], with acc shifting right.
  - Update carry<=cell cout, shift a_sh and b_sh right, count+1.
  - When count==WIDTH-1: update sum and cout from the final shifted values, set out_valid<=1, go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_valid is ignored while in RUN and DONE.
- sum and cout change only on completion. They keep their value after the output handshake until the next completion.
- Result equals {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).
- Reset mid-operation aborts the operation and discards it. No partial result is presented.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, sum=0, cout=0.
  - state=IDLE; internal shift registers, carry and count all 0.
- The accept edge is E0. RUN occupies edges E0+1..E0+WIDTH. out_valid is high from the edge E0+WIDTH.
- Latency from accept to out_valid: WIDTH cycles.
- Minimum initiation interval: WIDTH+2 cycles, with out_ready held high and in_valid held high.
- in_ready is low from E0 until the edge after the output handshake.
- The block does not accept new operands and hand off a result in the same cycle.
- out_valid must not drop without out_ready.
- rst has priority over every transition, including a handshake in the same cycle.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists.
  - With sub=1 on accept: B bits are inverted as they are shifted into the cell, the carry is initialised to 1, and cin is ignored.
  - Result: sum = a - b mod 2^WIDTH; cout=1 means no borrow (a>=b, unsigned).
  - With sub=0, behaviour is identical to the build without the macro.
- SERIAL_ADD_SUB_EN undefined: no sub port; addition only.

## Structure
- Shared package serial_add_pkg holds:
  - state typedef (enum IDLE/RUN/DONE, 2-bit encoding);
  - count width constant: $clog2 of the maximum WIDTH (32), i.e. 5 bits.
- Sub-module fa_cell, instantiated once: purely combinational one-bit full adder (a, b, c -> sum, cout).
- The controller holds all registers, the FSM and the handshakes.

## Test plan
- Reset: rst high for 2 cycles -> in_ready=1, out_valid=0, sum=8'h00, cout=0. rst high during a handshake -> state stays IDLE.
- WIDTH=8, a=8'h35, b=8'h4A, cin=0 -> out_valid exactly 8 cycles after accept; sum=8'h7F, cout=0. Then a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: out_ready=0 for 10 cycles after completion -> out_valid stays 1, sum/cout stable, in_ready=0. A new in_valid in that window is not accepted; it is taken only after the out_ready handshake.
- Abort: assert rst on the 3rd RUN cycle of a=8'hAA, b=8'h55 -> next cycle IDLE, out_valid=0, sum=8'h00. A following op a=8'h01, b=8'h02 -> sum=8'h03.
- Throughput: 4 back-to-back ops with in_valid and out_ready held high -> accepts spaced exactly WIDTH+2=10 cycles apart; all results correct.
- SERIAL_ADD_SUB_EN: a=8'h10, b=8'h03, sub=1 -> sum=8'h0D, cout=1. a=8'h03, b=8'h10, sub=1 -> sum=8'hF3, cout=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the bit-counter width sized for the largest legal WIDTH.
package serial_add_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(MAX_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Index of the last bit position for a given operand width.
    function automatic logic [CNT_W-1:0] last_bit_idx(input int unsigned width);
        return CNT_W'(width - 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand / result handshake bundle for serial_add_ctrl.
// The sub select exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Producer/consumer side (drives operands, takes results).
    modport master (
        output in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder, the single arithmetic cell time-shared over all
// bit positions by serial_add_ctrl. Purely combinational.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ c_i;
    assign cout_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Accepts an operand pair, pushes it LSB
// first through one fa_cell over WIDTH cycles with a registered carry,
// then holds {cout,sum} until the consumer takes it.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub select; B is
// inverted bit by bit and the carry starts at 1 to form a - b).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = last_bit_idx(WIDTH);

    state_e           state_q,     state_d;
    // A operand shift register; it doubles as the sum accumulator because
    // each A bit consumed at the LSB frees the MSB slot the new sum bit needs.
    logic [WIDTH-1:0] a_acc_q,     a_acc_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic             carry_q,     carry_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_q,       sub_d;
`endif

    logic             b_bit_s;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] a_acc_shift_s;

`ifdef SERIAL_ADD_SUB_EN
    assign b_bit_s = b_sh_q[0] ^ sub_q;
`else
    assign b_bit_s = b_sh_q[0];
`endif

    fa_cell u_fa_cell (
        .a_i    (a_acc_q[0]),
        .b_i    (b_bit_s),
        .c_i    (carry_q),
        .sum_o  (fa_sum_s),
        .cout_o (fa_cout_s)
    );

    assign a_acc_shift_s = {fa_sum_s, a_acc_q[WIDTH-1:1]};

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        a_acc_d     = a_acc_q;
        b_sh_d      = b_sh_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_ADD_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_acc_d    = bus.a;
                    b_sh_d     = bus.b;
                    cnt_d      = {CNT_W{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = RUN;
`ifdef SERIAL_ADD_SUB_EN
                    sub_d      = bus.sub;
                    carry_d    = bus.sub ? 1'b1 : bus.cin;
`else
                    carry_d    = bus.cin;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_acc_d = a_acc_shift_s;
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_cout_s;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_IDX) begin
                    sum_d       = a_acc_shift_s;
                    cout_d      = fa_cout_s;
                    out_valid_d = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_acc_q     <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_acc_q     <= a_acc_d;
            b_sh_q      <= b_sh_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_ADD_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (result = arithmetic sum, timing = fixed latency).
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sub_v = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

`ifdef SERIAL_ADD_SUB_EN
    assign bus.sub = sub_v;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Transaction-level model state.
    logic         m_idle = 1'b1;
    logic         m_ov   = 1'b0;
    logic [W:0]   m_res  = '0;
    logic [W:0]   m_pend = '0;
    int           m_left = 0;
    int           acc_cnt = 0;
    int           acc_times[$];

    function automatic logic [W:0] ref_calc(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                            input logic tc, input logic ts);
        logic [W-1:0] d;
        if (ts) begin
            d = ta - tb_;
            return {(ta >= tb_) ? 1'b1 : 1'b0, d};
        end
        return {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: accept when idle, result appears W cycles later, held until taken.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_idle <= 1'b1;
            m_ov   <= 1'b0;
            m_res  <= '0;
            m_left <= 0;
        end else if (m_idle) begin
            if (bus.in_valid) begin
                m_idle  <= 1'b0;
                m_left  <= W;
                m_pend  <= ref_calc(bus.a, bus.b, bus.cin, sub_v);
                acc_cnt <= acc_cnt + 1;
                acc_times.push_back(cyc);
            end
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_ov  <= 1'b1;
                m_res <= m_pend;
            end
        end else if (m_ov && bus.out_ready) begin
            m_ov   <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (bus.in_ready !== m_idle || bus.out_valid !== m_ov ||
                {bus.cout, bus.sum} !== m_res) begin
                fails++;
                $display("FAIL cycle_cmp cyc=%0d in_ready=%b exp %b out_valid=%b exp %b res=%h exp %h",
                         cyc, bus.in_ready, m_idle, bus.out_valid, m_ov, {bus.cout, bus.sum}, m_res);
            end
        end
    end

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic ts, input string nm);
        int start;
        int n;
        @(posedge clk); #1;
        bus.a = ta; bus.b = tb_; bus.cin = tc; sub_v = ts;
        bus.in_valid = 1'b1;
        start = acc_cnt;
        n = 0;
        while (acc_cnt == start && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (acc_cnt == start) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input logic [W:0] exp, input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || n >= 40) break;
            n++;
        end
        chk({nm, "_latency"}, n, W);
        chk({nm, "_result"}, {bus.cout, bus.sum}, exp);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int first;
        int n;
        int start;
        logic [W:0] held;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        // Pin the reference model to hand-computed values.
        chk("model_35_4a", ref_calc(8'h35, 8'h4A, 1'b0, 1'b0), 9'h07F);
        chk("model_ff_01", ref_calc(8'hFF, 8'h01, 1'b0, 1'b0), 9'h100);
        chk("model_ff_ff_c", ref_calc(8'hFF, 8'hFF, 1'b1, 1'b0), 9'h1FF);
        chk("model_sub_10_03", ref_calc(8'h10, 8'h03, 1'b1, 1'b1), 9'h10D);
        chk("model_sub_03_10", ref_calc(8'h03, 8'h10, 1'b0, 1'b1), 9'h0F3);

        // Reset for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sum", bus.sum, 8'h00);
        chk("rst_cout", bus.cout, 1'b0);

        // Reset wins over an accept in the same cycle.
        @(posedge clk); #1;
        start = acc_cnt;
        rst = 1'b1; bus.in_valid = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_hs_in_ready", bus.in_ready, 1'b1);
        chk("rst_hs_out_valid", bus.out_valid, 1'b0);

        // Directed sums.
        start_op(8'h35, 8'h4A, 1'b0, 1'b0, "add_35_4a");
        wait_done(9'h07F, "add_35_4a");
        handshake();
        start_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        wait_done(9'h100, "add_ff_01");
        handshake();
        start_op(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");
        wait_done(9'h1FF, "add_ff_ff_c");

        // Backpressure: result held, new operands refused until handshake.
        held = {bus.cout, bus.sum};
        start = acc_cnt;
        bus.a = 8'h21; bus.b = 8'h43; bus.cin = 1'b1; sub_v = 1'b0;
        bus.in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_out_valid", bus.out_valid, 1'b1);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        chk("bp_result_stable", {bus.cout, bus.sum}, held);
        chk("bp_no_accept", acc_cnt, start);
        handshake();
        n = 0;
        while (acc_cnt == start && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("bp_accept_after_hs", acc_cnt, start + 1);
        wait_done(9'h065, "bp_pending_op");
        chk("bp_result_kept", {bus.cout, bus.sum}, 9'h065);
        handshake();

        // Abort mid-run.
        start_op(8'hAA, 8'h55, 1'b0, 1'b0, "abort");
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_in_ready", bus.in_ready, 1'b1);
        chk("abort_sum", bus.sum, 8'h00);
        start_op(8'h01, 8'h02, 1'b0, 1'b0, "post_abort");
        wait_done(9'h003, "post_abort");
        handshake();

`ifdef SERIAL_ADD_SUB_EN
        start_op(8'h10, 8'h03, 1'b0, 1'b1, "sub_10_03");
        wait_done(9'h10D, "sub_10_03");
        handshake();
        start_op(8'h03, 8'h10, 1'b1, 1'b1, "sub_03_10");
        wait_done(9'h0F3, "sub_03_10");
        handshake();
        sub_v = 1'b0;
`endif

        // Throughput: in_valid and out_ready held high.
        @(posedge clk); #1;
        first = acc_times.size();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        n = 0;
        while (acc_times.size() < first + 4 && n < 200) begin
            start = acc_times.size();
            @(posedge clk); #1;
            if (acc_times.size() != start) begin
                bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
            end
            n++;
        end
        bus.in_valid = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("tput_accepts", acc_times.size(), first + 4);
        for (int k = 1; k < 4; k++) begin
            if (acc_times.size() > first + k)
                chk("tput_spacing", acc_times[first + k] - acc_times[first + k - 1], W + 2);
        end

        // Randomized traffic with random stalls on both sides.
        start = acc_cnt;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sub_v   = 1'($urandom);
`endif
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("rand_progress", (acc_cnt - start) > 20, 1'b1);
        chk("rand_drained_idle", bus.in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog_timeout tests=%0d fails=%0d", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
